demux_router_1to4: RTL

DEMUX_ROUTER_1TO4 -- requirements
Module: demux_router_1to4

---
 rtl/demux_router_1to4.sv | 86 ++++++++
 1 files changed

// File: rtl/demux_router_1to4.sv
// In-order 1-to-4 word router: input FIFO feeding four one-entry output slots.
// The FIFO head dispatches only when its destination slot is free or draining.
module demux_router_1to4 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_select,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [CW-1:0]     fifo_count
);

    logic [DATA_W+1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DATA_W-1:0] out_q [4];

    logic [DATA_W-1:0] head_data;
    logic [1:0]        head_sel;
    logic [3:0]        slot_free;
    logic              accept;
    logic              dispatch;

    assign head_data = mem[rptr][DATA_W+1:2];
    assign head_sel  = mem[rptr][1:0];
    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = fifo_count < CW'(DEPTH);
    assign accept    = in_valid && in_ready;
    assign dispatch  = (fifo_count != '0) && slot_free[head_sel];

    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem[wptr] <= {in_data, in_select};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            out_valid  <= '0;
            for (int k = 0; k < 4; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                wptr <= wptr + AW'(1);
            end
            if (dispatch) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({accept, dispatch})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            for (int k = 0; k < 4; k++) begin
                if (dispatch && head_sel == 2'(k)) begin
                    out_q[k]     <= head_data;
                    out_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule
